// File: rtl/warships_link_pkg.sv
// warships_link_pkg: shared link frame layout constants and receiver state encoding
package warships_link_pkg;
  localparam int LINK_PAYLOAD_BITS = 10;
  localparam int LINK_CORDS_BITS = 8;
  localparam int HIT_POS = 8;
  localparam int READY_POS = 9;
  localparam logic LINK_IDLE_LEVEL = 1'b1;
  localparam logic [LINK_CORDS_BITS-1:0] NO_CORDS = 8'hFF;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERR} link_rx_state_t;
endpackage

// File: rtl/link_sync.sv
// link_sync: STAGES-deep flop chain bringing an async level into the clk domain
module link_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  // shift the async level through the chain; reset presets every flop to the idle level
  always_ff @(posedge clk)
    r_chain <= !rst ? {STAGES{RST_VAL}} : {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/player_link_rx.sv
// player_link_rx: deserializes opponent link frames into {ready2, hit2, ship_cords_in}; LINK_PARITY_EN adds an even-parity bit
module player_link_rx
  import warships_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  output logic                       ready2,
  output logic                       hit2,
  output logic [LINK_CORDS_BITS-1:0] ship_cords_in,
  output logic                       frame_valid,
  output logic                       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef LINK_PARITY_EN
  localparam link_rx_state_t AFTER_DATA = PARITY;
`else
  localparam link_rx_state_t AFTER_DATA = STOP;
`endif
  link_rx_state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0] r_idx, w_idx;
  logic [LINK_PAYLOAD_BITS-1:0] r_shift, w_shift;
  logic r_par_ok, w_par_ok;
  logic w_rx_s, w_tick, w_done, w_fail;
  link_sync #(.STAGES(SYNC_STAGES), .RST_VAL(LINK_IDLE_LEVEL)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(rx),
    .o_q(w_rx_s)
  );
  assign w_tick = r_cnt == '0;
  // next-state logic: every bit decision is taken at the bit centre when the baud counter hits zero
  always_comb begin
    w_state = r_state;
    w_cnt = w_tick ? r_cnt : r_cnt - 1'b1;
    w_idx = r_idx;
    w_shift = r_shift;
    w_par_ok = r_par_ok;
    w_done = 1'b0;
    w_fail = 1'b0;
    case (r_state)
      IDLE: if (!w_rx_s) begin
        w_state = START;
        w_cnt = HALF;
        w_par_ok = 1'b1;
      end
      START: if (w_tick) begin
        w_state = w_rx_s ? IDLE : DATA;
        w_cnt = FULL;
        w_idx = '0;
      end
      DATA: if (w_tick) begin
        w_shift = {w_rx_s, r_shift[LINK_PAYLOAD_BITS-1:1]};
        w_cnt = FULL;
        w_idx = r_idx + 1'b1;
        if (r_idx == 4'(LINK_PAYLOAD_BITS - 1)) begin
          w_state = AFTER_DATA;
          w_idx = '0;
        end
      end
`ifdef LINK_PARITY_EN
      PARITY: if (w_tick) begin
        w_state = STOP;
        w_cnt = FULL;
        w_par_ok = w_rx_s == ^r_shift;
      end
`endif
      STOP: if (w_tick) begin
        w_done = w_rx_s && r_par_ok;
        w_fail = !w_done;
        w_state = w_done ? IDLE : ERR;
        w_cnt = FULL;
      end
      ERR: begin
        w_cnt = w_rx_s ? w_cnt : FULL;
        if (w_rx_s && w_tick) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  // state, counters and registered outputs; payload lands on the outputs together with frame_valid
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_par_ok <= 1'b1;
      ready2 <= 1'b0;
      hit2 <= 1'b0;
      ship_cords_in <= NO_CORDS;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_idx <= w_idx;
      r_shift <= w_shift;
      r_par_ok <= w_par_ok;
      frame_valid <= w_done;
      frame_err <= w_fail;
      if (w_done) begin
        ready2 <= r_shift[READY_POS];
        hit2 <= r_shift[HIT_POS];
        ship_cords_in <= r_shift[LINK_CORDS_BITS-1:0];
      end
    end
endmodule

// File: tb/tb_player_link_rx.sv
// tb_player_link_rx: scoreboard bench for player_link_rx; parity cases compiled with LINK_PARITY_EN
module tb_player_link_rx;
  localparam int CPB = 8;
  typedef struct packed {
    logic err;
    logic ready;
    logic hit;
    logic [7:0] cords;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic ready2, hit2, frame_valid, frame_err;
  logic [7:0] ship_cords_in;
  exp_t q[$];
  exp_t cur;
  exp_t e;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  player_link_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .ready2(ready2),
    .hit2(hit2),
    .ship_cords_in(ship_cords_in),
    .frame_valid(frame_valid),
    .frame_err(frame_err)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) cur = '{err: 1'b0, ready: 1'b0, hit: 1'b0, cords: 8'hFF};
    else if (frame_valid || frame_err) begin
      chk("pulse_exclusive", 16'(frame_valid & frame_err), 16'(0));
      if (q.size() == 0) chk("unexpected_pulse", 16'({frame_valid, frame_err}), 16'(0));
      else begin
        e = q.pop_front();
        chk("pulse_kind", 16'(frame_err), 16'(e.err));
        if (!e.err) cur = e;
        chk("pulse_outputs", 16'({ready2, hit2, ship_cords_in}), 16'({cur.ready, cur.hit, cur.cords}));
      end
    end
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] c, input logic h, input logic r, input logic bad_par, input logic bad_stop);
    logic [9:0] p;
    p = {r, h, c};
    q.push_back('{err: bad_par | bad_stop, ready: r, hit: h, cords: c});
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(p[i]);
`ifdef LINK_PARITY_EN
    send_bit(^p ^ bad_par);
`endif
    send_bit(!bad_stop);
  endtask
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 16'(q.size()), 16'(0));
    chk({tag, "_level"}, 16'({ready2, hit2, ship_cords_in}), 16'({cur.ready, cur.hit, cur.cords}));
  endtask
  initial begin
    logic [9:0] p;
    repeat (3) @(negedge clk);
    chk("rst_ready2", 16'(ready2), 16'(0));
    chk("rst_hit2", 16'(hit2), 16'(0));
    chk("rst_cords", 16'(ship_cords_in), 16'(8'hFF));
    chk("rst_valid", 16'(frame_valid), 16'(0));
    chk("rst_err", 16'(frame_err), 16'(0));
    rst = 1'b1;
    send_bit(1'b1);
    send_frame(8'h37, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    drain("valid_37");
    chk("valid_37_cords", 16'(ship_cords_in), 16'(8'h37));
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    drain("glitch");
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    send_frame(8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    drain("stop_err");
    chk("after_err_cords", 16'({ready2, hit2, ship_cords_in}), 16'({1'b1, 1'b0, 8'h42}));
`ifdef LINK_PARITY_EN
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("bad_parity");
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    drain("good_parity");
`endif
    p = {1'b1, 1'b1, 8'h6E};
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(p[i]);
    rx = p[5];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", 16'({ready2, hit2, ship_cords_in}), 16'({1'b0, 1'b0, 8'hFF}));
    chk("midrst_pulses", 16'({frame_valid, frame_err}), 16'(0));
    rst = 1'b1;
    rx = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    drain("after_rst");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h9E, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    drain("back_to_back");
    chk("b2b_final", 16'({ready2, hit2, ship_cords_in}), 16'({1'b1, 1'b0, 8'h9E}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
